ex_muldiv: RTL and testbench
============================

// Module: ex_muldiv
// PURPOSE
//  Iterative multiply/divide unit in the EX stage; consumes the rs/rt operands and decoded op from the ID/EX latch.
//  Executes MULT, MULTU, DIV and DIVU into architectural HI/LO registers; also services MTHI/MTLO writes.
//  Shift-add multiply and restoring divide, one bit per cycle. busy feeds the hazard unit, which holds ID/EX and
//  upstream latches while an operation runs; the hazard unit also drives flush on a squash.
// PARAMETERS
//  WIDTH  32  operand and HI/LO width; even, >=4. The counter is $clog2(WIDTH) bits wide.
// PORTS
//  CLK      in   1      clock, rising edge
//  nRST     in   1      asynchronous active-low reset
//  start    in   1      request a new op; sampled only in IDLE
//  op       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  rs_data  in   WIDTH  multiplicand / dividend
//  rt_data  in   WIDTH  multiplier / divisor
//  flush    in   1      abort the in-flight op (branch/exception squash)
//  wr_hi    in   1      MTHI: hi <= wdat
//  wr_lo    in   1      MTLO: lo <= wdat
//  wdat     in   WIDTH  MTHI/MTLO data
//  busy     out  1      op in flight (state != IDLE)
//  done     out  1      one-cycle pulse; hi/lo hold the new result while it is high
//  hi       out  WIDTH  HI register
//  lo       out  WIDTH  LO register
// BEHAVIOUR
//  Reset (nRST=0, asynchronous, any state):
//   - state=IDLE; hi, lo, done, busy, counter and datapath regs = 0.
//  FSM: IDLE -> CALC -> FIX -> IDLE.
//  IDLE:
//   - start=1 at edge E0 latches op, the operand magnitudes and the result-sign flags; counter=WIDTH-1; -> CALC.
//  CALC:
//   - One iteration per edge. MUL: conditional add, then shift of the 2*WIDTH product. DIV: restoring subtract/shift.
//   - Edge with counter=0 -> FIX; otherwise counter decrements.
//  FIX:
//   - On the edge: apply sign correction, write hi/lo, set done=1; -> IDLE.
//   - done clears on the following edge.
//  Latency: without the macro, hi/lo update on edge E(WIDTH+1); done is high in the cycle after that edge.
//   - busy is high for WIDTH+1 cycles.
//  Results:
//   - MUL: {hi,lo} = 2*WIDTH product. Signed product is negated when the operand signs differ.
//   - DIV: lo = quotient, hi = remainder. Quotient is negative when signs differ; remainder takes the dividend's sign.
//   - Signed divide of -2^(W-1) by -1: lo = 0x80000000, hi = 0 (wraps, no trap).
//   - Divide by zero (DIV/DIVU): hi = rs_data as latched, lo = all ones, no sign correction, normal latency.
//  Simultaneous events:
//   - start while busy: ignored, not queued.
//   - flush=1 at any edge in CALC/FIX: -> IDLE; hi/lo unchanged; no done. flush beats start at the same edge.
//   - flush in IDLE: no effect.
//   - wr_hi/wr_lo: take effect only in IDLE (the done cycle counts as IDLE); ignored while busy.
//   - wr_hi/wr_lo with start at the same edge: the write applies, the op is accepted, and its result later overwrites.
//  Unsigned arithmetic throughout; magnitudes use two's-complement negation in WIDTH bits.
// CONFIGURATION
//  MULDIV_EARLY_EXIT_EN:
//   - Defined: MULT/MULTU leave CALC for FIX at the first CALC edge after which the remaining multiplier bits are
//     all zero; the product is identical.
//   - Example: rt magnitude 1 or 0 -> hi/lo update on E2.
//  Undefined: every op takes the fixed WIDTH CALC cycles. Divide latency is fixed in both builds.
// TESTING
//  1. MULTU FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE, lo=00000001; done exactly 33 cycles after the accept edge; busy 33 cycles.
//  2. MULT -3*7 -> hi=FFFFFFFF, lo=FFFFFFEB. DIV -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF.
//  3. DIVU 7/0 -> hi=00000007, lo=FFFFFFFF. DIV 80000000/FFFFFFFF -> lo=80000000, hi=00000000.
//  4. MULTU with flush in CALC cycle 10, start also high -> busy low next cycle, hi/lo unchanged, done never pulses.
//  5. wr_hi=1, wdat=DEADBEEF while busy -> ignored; same write in IDLE -> hi=DEADBEEF next cycle.
//  6. nRST low mid-DIV -> all outputs 0 immediately. With MULDIV_EARLY_EXIT_EN: MULTU 5*1 -> lo=5, done 2 cycles after accept.

Source files
------------

// File: rtl/ex_muldiv_if.sv
// Bundle of the EX-stage multiply/divide unit's request, control and result signals.
// The pipeline side (ID/EX latch, hazard unit) drives through the master modport;
// ex_muldiv attaches through the slave modport. dbg_state mirrors the unit's FSM state.
interface ex_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             flush;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdat;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [1:0]       dbg_state;

    modport master (
        output start, op, rs_data, rt_data, flush, wr_hi, wr_lo, wdat,
        input  busy, done, hi, lo, dbg_state
    );

    modport slave (
        input  start, op, rs_data, rt_data, flush, wr_hi, wr_lo, wdat,
        output busy, done, hi, lo, dbg_state
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit for the EX stage with architectural HI/LO.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division, one bit per CALC cycle;
// FIX applies sign correction and writes HI/LO. MTHI/MTLO writes land only in IDLE.
// Handshake: start is sampled only while busy is low; a request seen while busy is
// dropped, never queued. done pulses for one cycle with HI/LO already holding the
// result. flush aborts an in-flight op (CALC/FIX) without touching HI/LO or pulsing done.
// Optional feature: define MULDIV_EARLY_EXIT_EN to let multiplies leave CALC as soon as
// the remaining multiplier bits are all zero (divide latency is unaffected).
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic        CLK,
    input  logic        nRST,
    ex_muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_is_div;
    logic             r_neg_q;    // negate product / quotient
    logic             r_neg_r;    // negate remainder (dividend was negative)
    logic             r_div0;
    logic [WIDTH-1:0] r_a;        // multiplicand magnitude / divisor magnitude
    logic [WIDTH-1:0] r_b;        // multiplier, then product low / dividend, then quotient
    logic [WIDTH-1:0] r_acc;      // product high / partial remainder
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    // Operand decode for the accept edge
    logic             w_signed;
    logic             w_rs_neg;
    logic             w_rt_neg;
    logic [WIDTH-1:0] w_rs_mag;
    logic [WIDTH-1:0] w_rt_mag;

    assign w_signed = ~bus.op[0];
    assign w_rs_neg = w_signed & bus.rs_data[WIDTH-1];
    assign w_rt_neg = w_signed & bus.rt_data[WIDTH-1];
    assign w_rs_mag = w_rs_neg ? -bus.rs_data : bus.rs_data;
    assign w_rt_mag = w_rt_neg ? -bus.rt_data : bus.rt_data;

    // One iteration of the multiply: conditional add, then shift of {acc, b}
    logic [WIDTH:0]   w_sum;
    assign w_sum = r_b[0] ? ({1'b0, r_acc} + {1'b0, r_a}) : {1'b0, r_acc};

    // One iteration of the restoring divide: shift in next dividend bit, trial subtract
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    assign w_shift = {r_acc, r_b[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_a});
    assign w_diff  = w_shift[WIDTH-1:0] - r_a;

    // Last CALC iteration detection
    logic             w_last;
    logic [2*WIDTH-1:0] w_prod;
`ifdef MULDIV_EARLY_EXIT_EN
    // r_cnt low multiplier bits remain after this edge's bit is consumed; when
    // they are zero the product only needs r_cnt further right shifts, done in FIX.
    logic [WIDTH-1:0] w_mask;
    assign w_mask = (WIDTH'(1) << r_cnt) - WIDTH'(1);
    assign w_last = (r_cnt == '0) || (!r_is_div && (((r_b >> 1) & w_mask) == '0));
    assign w_prod = {r_acc, r_b} >> r_cnt;
`else
    assign w_last = (r_cnt == '0);
    assign w_prod = {r_acc, r_b};
`endif

    // Sign-corrected results presented in FIX
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quot     = r_div0 ? '1 : (r_neg_q ? -r_b : r_b);
    assign w_rem      = r_neg_r ? -r_acc : r_acc;

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; flush wins over everything outside IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.start) w_next = S_CALC;
            S_CALC: begin
                if (bus.flush)   w_next = S_IDLE;
                else if (w_last) w_next = S_FIX;
            end
            S_FIX:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath, counter, HI/LO and done pulse
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.wr_hi) r_hi <= bus.wdat;
                    if (bus.wr_lo) r_lo <= bus.wdat;
                    if (bus.start) begin
                        r_is_div <= bus.op[1];
                        r_neg_q  <= w_rs_neg ^ w_rt_neg;
                        r_neg_r  <= w_rs_neg;
                        r_div0   <= bus.op[1] && (bus.rt_data == '0);
                        r_a      <= bus.op[1] ? w_rt_mag : w_rs_mag;
                        r_b      <= bus.op[1] ? w_rs_mag : w_rt_mag;
                        r_acc    <= '0;
                        r_cnt    <= CW'(WIDTH - 1);
                    end
                end
                S_CALC: begin
                    if (!bus.flush) begin
                        if (r_is_div) begin
                            r_acc <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                            r_b   <= {r_b[WIDTH-2:0], w_ge};
                        end else begin
                            r_acc <= w_sum[WIDTH:1];
                            r_b   <= {w_sum[0], r_b[WIDTH-1:1]};
                        end
                        if (!w_last) r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_FIX: begin
                    if (!bus.flush) begin
                        if (r_is_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end else begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: results come from a native-arithmetic model, are queued
// when an op is issued and popped when done pulses.
module tb_ex_muldiv;
    localparam int W = 32;

    logic CLK = 1'b0;
    logic nRST = 1'b0;

    ex_muldiv_if #(.WIDTH(W)) bus();

    ex_muldiv #(.WIDTH(W)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    logic [2*W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: res = sa * sb;
            2'b01: res = {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == '0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == '0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    // Edges from accept to the edge after which done is visible
    function automatic int exp_lat(input logic [1:0] op, input logic [W-1:0] b);
        if (op[1]) return W + 1;
`ifdef MULDIV_EARLY_EXIT_EN
        begin
            logic [W-1:0] m;
            int k;
            m = (op == 2'b00 && b[W-1]) ? -b : b;
            k = 1;
            for (int i = 0; i < W; i++) if (m[i]) k = i + 1;
            return k + 1;
        end
`else
        return W + 1;
`endif
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit fl, input bit wlo, input logic [W-1:0] wd, input bit whi_busy);
        int lat;
        int busy_cnt;
        logic [63:0] r;
        bus.start   = 1'b1;
        bus.op      = op;
        bus.rs_data = a;
        bus.rt_data = b;
        bus.flush   = fl;
        bus.wr_lo   = wlo;
        bus.wdat    = wd;
        exp_q.push_back(model(op, a, b));
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.wr_lo = 1'b0;
        if (wlo) begin
            m_lo = wd;
            chk("wr_lo_with_start", bus.lo, m_lo);
        end
        chk("busy_after_accept", bus.busy, 1);
        lat = 0;
        busy_cnt = 1;
        while (!bus.done && lat < 100) begin
            bus.wr_hi = whi_busy && (lat == 0);
            bus.wdat  = 32'hDEAD_BEEF;
            tick();
            bus.wr_hi = 1'b0;
            lat++;
            if (bus.busy) busy_cnt++;
        end
        chk("done_seen", bus.done, 1);
        chk("latency", lat, exp_lat(op, b));
        chk("busy_cycles", busy_cnt, exp_lat(op, b));
        chk("busy_at_done", bus.busy, 0);
        if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            m_hi = r[63:32];
            m_lo = r[31:0];
            chk("hi", bus.hi, m_hi);
            chk("lo", bus.lo, m_lo);
        end
        tick();
        chk("done_clear", bus.done, 0);
    endtask

    initial begin
        int pulses;
        int busy_seen;
        bus.start = 1'b0; bus.op = 2'b00; bus.rs_data = '0; bus.rt_data = '0;
        bus.flush = 1'b0; bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wdat = '0;

        // Reset values
        #12;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        chk("rst_state", bus.dbg_state, 0);
        @(negedge CLK);
        nRST = 1'b1;
        tick();

        // Multiply and divide basics, including signs and corner cases
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, '0, 0);
        run_op(2'b00, -32'sd3, 32'd7, 0, 0, '0, 0);
        run_op(2'b10, -32'sd7, 32'd2, 0, 0, '0, 0);
        run_op(2'b11, 32'd7, 32'd0, 0, 0, '0, 0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, '0, 0);
        run_op(2'b10, -32'sd5, 32'd0, 0, 0, '0, 0);
        run_op(2'b10, 32'd100, -32'sd7, 0, 0, '0, 0);

        // Flush mid-CALC with start also asserted: abort, nothing accepted
        bus.start = 1'b1; bus.op = 2'b01; bus.rs_data = 32'h1234_5678; bus.rt_data = 32'hFFFF_FFFF;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        bus.flush = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.start = 1'b0;
        chk("flush_busy", bus.busy, 0);
        chk("flush_state", bus.dbg_state, 0);
        chk("flush_hi", bus.hi, m_hi);
        chk("flush_lo", bus.lo, m_lo);
        pulses = 0;
        busy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done) pulses++;
            if (bus.busy) busy_seen++;
        end
        chk("flush_no_done", pulses, 0);
        chk("flush_no_restart", busy_seen, 0);

        // HI write while busy is ignored; writes in IDLE land
        run_op(2'b00, 32'd12345, -32'sd9, 0, 0, '0, 1);
        bus.wr_hi = 1'b1; bus.wdat = 32'hDEAD_BEEF;
        tick();
        bus.wr_hi = 1'b0;
        m_hi = 32'hDEAD_BEEF;
        chk("mthi_idle", bus.hi, m_hi);
        bus.wr_lo = 1'b1; bus.wdat = 32'h0BAD_F00D;
        tick();
        bus.wr_lo = 1'b0;
        m_lo = 32'h0BAD_F00D;
        chk("mtlo_idle", bus.lo, m_lo);
        chk("mtlo_keeps_hi", bus.hi, m_hi);

        // Flush in IDLE has no effect (start accepted); write alongside start
        run_op(2'b11, 32'd1000, 32'd7, 1, 0, '0, 0);
        run_op(2'b00, 32'd3, 32'd4, 0, 1, 32'hCAFE_F00D, 0);

        // Small multipliers (early-exit candidates)
        run_op(2'b01, 32'd5, 32'd1, 0, 0, '0, 0);
        run_op(2'b00, 32'd9, 32'd0, 0, 0, '0, 0);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, '0, 0);
        run_op(2'b01, 32'h0001_0000, 32'h0000_0300, 0, 0, '0, 0);

        // Random operations
        for (int i = 0; i < 6; i++) begin
            logic [1:0] rop;
            logic [W-1:0] ra, rb;
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 2) ? 32'd0 : 32'($urandom_range(0, 32'hFFFF)) << $urandom_range(0, 16);
            run_op(rop, ra, rb, 0, 0, '0, 0);
        end

        // Asynchronous reset in the middle of a divide
        bus.start = 1'b1; bus.op = 2'b10; bus.rs_data = 32'd77; bus.rt_data = 32'd5;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        #2;
        nRST = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_hi", bus.hi, 0);
        chk("arst_lo", bus.lo, 0);
        m_hi = '0;
        m_lo = '0;
        @(negedge CLK);
        nRST = 1'b1;
        tick();
        run_op(2'b10, 32'd77, 32'd5, 0, 0, '0, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
